// File: rtl/lap_stopwatch.sv
// lap_stopwatch: stopwatch / countdown timer with a lap-capture FIFO.
//
// A four-state control machine (IDLE, RUN, PAUSE, DONE) drives a WIDTH-bit
// counter that advances once every PRESCALE clocks while running. The
// counter counts up (saturating or wrapping at all-ones) or down (ending in
// DONE when it reaches zero). Lap requests push the current count into a
// first-word-fall-through FIFO that a host drains through a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        run / resume request
//   stop         pause request
//   clear        return to IDLE, zero the count, flush the laps
//   lap          capture the current count into the lap FIFO
//   mode         0 = count up, 1 = count down (latched when a run starts)
//   load         preload request (IDLE or PAUSE)
//   load_val     preload value
//   elapsed      current count
//   running      high while in RUN
//   expired      high while in DONE
//   lap_data     FIFO head, first-word-fall-through
//   lap_valid    FIFO non-empty
//   lap_ready    host accepts the head
//   lap_count    FIFO occupancy
//   lap_overflow sticky: a lap was dropped because the FIFO was full
//   dbg_state    current control state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
//
// Handshake: the lap read port follows strict valid/ready rules. lap_data is
// meaningful only while lap_valid is high and holds steady until popped; a
// pop happens on every rising edge where lap_valid and lap_ready are both
// high, and lap_ready alone never changes the FIFO.

module lap_stopwatch #(
  parameter int WIDTH     = 16,
  parameter int PRESCALE  = 1,
  parameter int LAP_DEPTH = 4,
  parameter bit WRAP      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         lap,
  input  logic                         mode,
  input  logic                         load,
  input  logic [WIDTH-1:0]             load_val,
  output logic [WIDTH-1:0]             elapsed,
  output logic                         running,
  output logic                         expired,
  output logic [WIDTH-1:0]             lap_data,
  output logic                         lap_valid,
  input  logic                         lap_ready,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow,
  output logic [1:0]                   dbg_state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic             mode_q;
  logic [WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic tick;
  logic start_ok;
  logic full;
  logic lap_ok;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    tick     = (state == S_RUN) && (presc == PRE_LAST);
    // A countdown that would start at zero has nothing to count.
    start_ok = start && !(mode && (elapsed == '0));
    full     = (lap_count == FULL_CNT);
    lap_ok   = lap && !clear && ((state == S_RUN) || (state == S_PAUSE));
    pop      = lap_valid && lap_ready && !clear;
    // A pop on the same edge frees the slot the new lap needs.
    push     = lap_ok && (!full || pop);
    drop     = lap_ok && full && !pop;
  end

  // Control state, counter and prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      elapsed <= '0;
      presc   <= '0;
      mode_q  <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
    end else if (clear) begin
      state   <= S_IDLE;
      elapsed <= '0;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // stop outranks start and load even though it has no IDLE action.
          if (!stop) begin
            if (start_ok) begin
              state   <= S_RUN;
              running <= 1'b1;
              mode_q  <= mode;
              presc   <= '0;
            end else if (load) begin
              elapsed <= load_val;
            end
          end
        end
        S_PAUSE: begin
          if (!stop) begin
            if (start_ok) begin
              // The prescaler is left alone so a partial tick carries over.
              state   <= S_RUN;
              running <= 1'b1;
              mode_q  <= mode;
            end else if (load) begin
              elapsed <= load_val;
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            presc <= '0;
            if (!mode_q) begin
              if (elapsed == CNT_MAX) begin
                if (WRAP) elapsed <= '0;
              end else begin
                elapsed <= elapsed + WIDTH'(1);
              end
            end else if (elapsed <= WIDTH'(1)) begin
              elapsed <= '0;
              state   <= S_DONE;
              running <= 1'b0;
              expired <= 1'b1;
            end else begin
              elapsed <= elapsed - WIDTH'(1);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        S_DONE: ;
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

  // Lap FIFO: circular buffer with an explicit occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lap_count    <= '0;
      lap_overflow <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lap_count    <= '0;
      lap_overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= elapsed;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      lap_count <= lap_count + CW'(1);
      else if (pop && !push) lap_count <= lap_count - CW'(1);
      if (drop) lap_overflow <= 1'b1;
    end
  end

  assign lap_valid = (lap_count != '0);
  assign lap_data  = mem[rd_ptr];
  assign dbg_state = state;

endmodule
